// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared sizing helpers for the pipelined CLA adder
package adder_pkg;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational carry-lookahead slice of SW bits
module cla_slice #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          c_msb
);

  logic [SW-1:0] g;
  logic [SW-1:0] p;
  logic [SW:0]   c;

  // Each carry is its own flattened g/p expression, so no carry waits on its neighbour.
  always_comb begin
    logic acc;
    acc = cin;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i <= SW; i++) begin
      acc = cin;
      for (int j = 0; j < i; j++) begin
        acc = g[j] | (p[j] & acc);
      end
      c[i] = acc;
    end
  end

  assign s     = p ^ c[SW-1:0];
  assign cout  = c[SW];
  assign c_msb = c[SW-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              c_init;
  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] adv;
  logic              ovf_q;

  assign b_eff  = sub ? ~b : b;
  assign c_init = sub | cin;

  // A stage may load when it or any stage downstream of it has a hole, or the sink drains.
  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    adv   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain  = chain | ~v_all[k];
      adv[k] = chain;
    end
  end

  assign in_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int OW = WIDTH - LO;

    logic             v_q;
    logic             c_q;
    logic [LO+SW-1:0] s_q;
    logic [LO+SW-1:0] nxt_s;
    logic             src_v;
    logic             src_c;
    logic [OW-1:0]    op_a;
    logic [OW-1:0]    op_b;
    logic [SW-1:0]    sl_s;
    logic             sl_cout;
    logic             sl_cmsb;

    if (k == 0) begin : g_src
      assign src_v = in_valid;
      assign src_c = c_init;
      assign op_a  = a;
      assign op_b  = b_eff;
      assign nxt_s = sl_s;
    end else begin : g_src
      assign src_v = g_stage[k-1].v_q;
      assign src_c = g_stage[k-1].c_q;
      assign op_a  = g_stage[k-1].g_ops.a_q;
      assign op_b  = g_stage[k-1].g_ops.b_q;
      assign nxt_s = {sl_s, g_stage[k-1].s_q};
    end

    cla_slice #(.SW(SW)) u_slice (
      .a     (op_a[SW-1:0]),
      .b     (op_b[SW-1:0]),
      .cin   (src_c),
      .s     (sl_s),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv[k]) begin
        v_q <= src_v;
        if (src_v) begin
          c_q <= sl_cout;
          s_q <= nxt_s;
        end
      end
    end

    // Only operand slices not yet consumed travel further down the pipe.
    if (k < STAGES - 1) begin : g_ops
      logic [OW-SW-1:0] a_q;
      logic [OW-SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && src_v) begin
          a_q <= op_a[OW-1:SW];
          b_q <= op_b[OW-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv[k] && src_v) begin
          ovf_q <= sl_cout ^ sl_cmsb;
        end
      end
    end

    assign v_all[k] = v_q;
  end

  assign out_valid = v_all[STAGES-1];
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = ovf_q;

endmodule
